// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// The PIPE_PERF_CNT_EN macro (see top) does not affect this package.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Hazard inputs and pipeline-register controls of the sequencer.
// Counter outputs are zero unless PIPE_PERF_CNT_EN is defined.
interface pipe_seq_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start_i;
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_uses_rt_i;
   logic             id_branch_i;
   logic             id_eq_i;
   logic             id_jump_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rt_i;
   logic             mem_req_i;
   logic             pc_we_o;
   logic             ifid_we_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             back_we_o;
   logic             running_o;
   logic [CNT_W-1:0] cycle_cnt_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output start_i, id_rs_i, id_rt_i, id_uses_rt_i,
      output id_branch_i, id_eq_i, id_jump_i,
      output ex_memread_i, ex_rt_i, mem_req_i,
      input  pc_we_o, ifid_we_o, ifid_flush_o,
      input  idex_bubble_o, back_we_o, running_o,
      input  cycle_cnt_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  start_i, id_rs_i, id_rt_i, id_uses_rt_i,
      input  id_branch_i, id_eq_i, id_jump_i,
      input  ex_memread_i, ex_rt_i, mem_req_i,
      output pc_we_o, ifid_we_o, ifid_flush_o,
      output idex_bubble_o, back_we_o, running_o,
      output cycle_cnt_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_seq_ctrl_hazard.sv
// ID-stage load-use detector: lw in EX writing a register read in ID.
// r0 is never a real dependency.
module pipe_hazard_unit
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);
   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = (ex_rt == id_rs);
   assign rt_hit   = id_uses_rt && (ex_rt == id_rt);
   assign load_use = ex_memread && (ex_rt != REG_ZERO)
                   && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: run gating, load-use stall, branch flush, mem freeze.
// Define PIPE_PERF_CNT_EN to build the cycle/stall/flush counters.
module pipe_seq_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   pipe_seq_ctrl_if.slave bus
);
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_t           state, state_nxt;
   logic [LAT_W-1:0] lat, lat_nxt;
   logic             done;
   logic             load_use;
   logic             freeze_c;
   logic             redirect;
   logic             pc_we, ifid_we, ifid_flush, bubble, back_we;

   pipe_hazard_unit u_hazard (
      .ex_memread (bus.ex_memread_i),
      .ex_rt      (bus.ex_rt_i),
      .id_rs      (bus.id_rs_i),
      .id_rt      (bus.id_rt_i),
      .id_uses_rt (bus.id_uses_rt_i),
      .load_use   (load_use)
   );

   assign freeze_c = bus.mem_req_i && (MEM_LAT > 0) && !done;
   assign redirect = bus.id_jump_i
                   || (bus.id_branch_i && bus.id_eq_i);

   always_comb begin
      state_nxt  = state;
      lat_nxt    = lat;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      bubble     = 1'b0;
      back_we    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start_i) state_nxt = RUN;
         end
         RUN: begin
            if (freeze_c) begin
               state_nxt = MEMWAIT;
               lat_nxt   = LAT_W'(MEM_LAT - 1);
            end else if (load_use) begin
               bubble  = 1'b1;
               back_we = 1'b1;
            end else if (redirect) begin
               pc_we      = 1'b1;
               ifid_we    = 1'b1;
               ifid_flush = 1'b1;
               back_we    = 1'b1;
            end else begin
               pc_we   = 1'b1;
               ifid_we = 1'b1;
               back_we = 1'b1;
            end
            // A pause still lets this cycle's enables act.
            if (!bus.start_i) state_nxt = IDLE;
         end
         MEMWAIT: begin
            if (lat == '0)
               state_nxt = bus.start_i ? RUN : IDLE;
            else
               lat_nxt = lat - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (!rst_i) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b0;
         bubble     = 1'b0;
         back_we    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         lat   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         lat   <= lat_nxt;
         // One-cycle marker so the finished access is not re-frozen.
         done  <= (state == MEMWAIT) && (lat == '0);
      end
   end

   assign bus.pc_we_o       = pc_we;
   assign bus.ifid_we_o     = ifid_we;
   assign bus.ifid_flush_o  = ifid_flush;
   assign bus.idex_bubble_o = bubble;
   assign bus.back_we_o     = back_we;
   assign bus.running_o     = (state != IDLE);

`ifdef PIPE_PERF_CNT_EN
   logic             cyc_ev, stall_ev, flush_ev;
   logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

   assign cyc_ev   = (state != IDLE);
   assign stall_ev = (state == MEMWAIT)
                   || ((state == RUN) && (freeze_c || load_use));
   assign flush_ev = (state == RUN) && !freeze_c
                   && !load_use && redirect;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cyc_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (cyc_ev)   cyc_q   <= cyc_q + 1'b1;
         if (stall_ev) stall_q <= stall_q + 1'b1;
         if (flush_ev) flush_q <= flush_q + 1'b1;
      end
   end

   assign bus.cycle_cnt_o = cyc_q;
   assign bus.stall_cnt_o = stall_q;
   assign bus.flush_cnt_o = flush_q;
`else
   assign bus.cycle_cnt_o = '0;
   assign bus.stall_cnt_o = '0;
   assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl with MEM_LAT=3.
// Counter expectations collapse to 0 unless PIPE_PERF_CNT_EN is defined.
module tb_pipe_seq_ctrl;
   import pipe_ctrl_pkg::*;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_RUN  = 6'b110011;
   localparam logic [5:0] C_LU   = 6'b000111;
   localparam logic [5:0] C_FL   = 6'b111011;
   localparam logic [5:0] C_FRZ  = 6'b000001;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   bit   exp_run = 1'b0;
   int   exp_cyc = 0;
   int   exp_stall = 0;
   int   exp_flush = 0;
   logic [5:0] ctl;

   pipe_seq_ctrl_if #(.CNT_W(32)) bus ();

   pipe_seq_ctrl #(.MEM_LAT(3), .CNT_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign ctl = {bus.pc_we_o, bus.ifid_we_o, bus.ifid_flush_o,
                 bus.idex_bubble_o, bus.back_we_o, bus.running_o};

   function automatic logic [31:0] cx(input int v);
      return PERF ? 32'(v) : 32'd0;
   endfunction

   task automatic clr_in();
      bus.id_rs_i      = 5'd0;
      bus.id_rt_i      = 5'd0;
      bus.id_uses_rt_i = 1'b0;
      bus.id_branch_i  = 1'b0;
      bus.id_eq_i      = 1'b0;
      bus.id_jump_i    = 1'b0;
      bus.ex_memread_i = 1'b0;
      bus.ex_rt_i      = 5'd0;
      bus.mem_req_i    = 1'b0;
   endtask

   task automatic tick(input bit st, input bit fl);
      if (exp_run) exp_cyc++;
      if (st) exp_stall++;
      if (fl) exp_flush++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string nm, input logic [5:0] e);
      #1;
      checks++;
      if (ctl !== e) begin
         failures++;
         $display("FAIL %s ctl got=%b exp=%b", nm, ctl, e);
      end
   endtask

   task automatic chk_cnt(input string nm);
      checks++;
      if (bus.cycle_cnt_o !== cx(exp_cyc)
          || bus.stall_cnt_o !== cx(exp_stall)
          || bus.flush_cnt_o !== cx(exp_flush)) begin
         failures++;
         $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                  nm, bus.cycle_cnt_o, bus.stall_cnt_o,
                  bus.flush_cnt_o, cx(exp_cyc), cx(exp_stall),
                  cx(exp_flush));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start_i = 1'b0;
      clr_in();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(0, 0);
         chk_ctl("reset_idle", C_IDLE);
      end
      chk_cnt("reset_cnt");
      bus.start_i = 1'b1;
      chk_ctl("start_same_cycle", C_IDLE);
      tick(0, 0);
      exp_run = 1'b1;
      chk_ctl("start_run", C_RUN);
      chk_cnt("start_cnt");
   endtask

   task automatic test_load_use();
      bus.ex_memread_i = 1'b1;
      bus.ex_rt_i      = 5'd8;
      bus.id_rs_i      = 5'd8;
      chk_ctl("lu_rs", C_LU);
      tick(1, 0);
      clr_in();
      chk_ctl("lu_release", C_RUN);
      chk_cnt("lu_cnt");
      bus.ex_memread_i = 1'b1;
      bus.ex_rt_i      = 5'd9;
      bus.id_rs_i      = 5'd3;
      bus.id_rt_i      = 5'd9;
      bus.id_uses_rt_i = 1'b1;
      chk_ctl("lu_rt", C_LU);
      bus.id_uses_rt_i = 1'b0;
      chk_ctl("lu_rt_unused", C_RUN);
      bus.id_uses_rt_i = 1'b1;
      tick(1, 0);
      clr_in();
   endtask

   task automatic test_r0();
      bus.ex_memread_i = 1'b1;
      bus.ex_rt_i      = 5'd0;
      bus.id_rs_i      = 5'd0;
      chk_ctl("r0_exempt", C_RUN);
      tick(0, 0);
      clr_in();
      chk_cnt("r0_cnt");
   endtask

   task automatic test_branch();
      bus.ex_memread_i = 1'b1;
      bus.ex_rt_i      = 5'd8;
      bus.id_rs_i      = 5'd8;
      bus.id_branch_i  = 1'b1;
      bus.id_eq_i      = 1'b1;
      chk_ctl("stall_beats_flush", C_LU);
      tick(1, 0);
      bus.ex_memread_i = 1'b0;
      chk_ctl("branch_taken", C_FL);
      tick(0, 1);
      bus.id_eq_i = 1'b0;
      chk_ctl("branch_not_taken", C_RUN);
      chk_cnt("branch_cnt");
      tick(0, 0);
      clr_in();
      bus.id_jump_i = 1'b1;
      chk_ctl("jump", C_FL);
      tick(0, 1);
      clr_in();
      chk_cnt("jump_cnt");
   endtask

   task automatic test_memwait();
      bus.mem_req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_ctl("mem_freeze", C_FRZ);
         tick(1, 0);
      end
      chk_ctl("mem_done_no_reentry", C_RUN);
      chk_cnt("mem_cnt");
      tick(0, 0);
      bus.mem_req_i = 1'b0;
      chk_ctl("mem_after", C_RUN);
   endtask

   task automatic test_reset_memwait();
      bus.mem_req_i = 1'b1;
      tick(1, 0);
      bus.mem_req_i = 1'b0;
      chk_ctl("rst_pre_memwait", C_FRZ);
      rst_n = 1'b0;
      bus.start_i = 1'b0;
      chk_ctl("rst_no_pulse", C_FRZ & 6'b000001);
      @(posedge clk);
      #1;
      exp_run = 1'b0;
      exp_cyc = 0;
      exp_stall = 0;
      exp_flush = 0;
      chk_ctl("rst_in_memwait", C_IDLE);
      chk_cnt("rst_cnt");
      rst_n = 1'b1;
      bus.start_i = 1'b1;
      tick(0, 0);
      exp_run = 1'b1;
      chk_ctl("restart", C_RUN);
   endtask

   task automatic test_stop_in_memwait();
      bus.mem_req_i = 1'b1;
      tick(1, 0);
      bus.mem_req_i = 1'b0;
      bus.start_i   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_ctl("stop_wait_completes", C_FRZ);
         tick(1, 0);
      end
      exp_run = 1'b0;
      chk_ctl("stop_to_idle", C_IDLE);
      chk_cnt("stop_cnt");
      tick(0, 0);
      tick(0, 0);
      chk_cnt("idle_hold_cnt");
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_r0();
      test_branch();
      test_memwait();
      test_reset_memwait();
      test_stop_in_memwait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout ran=%0t limit=100000", $time);
      $fatal(1);
   end

endmodule
